// File: rtl/booth_pp_accumulator_if.sv
// rtl/booth_pp_accumulator_if.sv - partial-product stream and product result bundle
interface booth_pp_accumulator_if #(
    parameter int N = 32
);
    logic             pp_valid;
    logic             pp_ready;
    logic [N+1:0]     pp_data;
    logic             prod_valid;
    logic             prod_ready;
    logic [2*N-1:0]   prod;
    logic             busy;

    // Accumulator side
    modport slave (
        input  pp_valid,
        input  pp_data,
        input  prod_ready,
        output pp_ready,
        output prod_valid,
        output prod,
        output busy
    );

    // Producer / consumer side
    modport master (
        output pp_valid,
        output pp_data,
        output prod_ready,
        input  pp_ready,
        input  prod_valid,
        input  prod,
        input  busy
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - serial carry-save accumulator for radix-4 Booth partial products
module booth_pp_accumulator #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    booth_pp_accumulator_if.slave bus
);
    localparam int W     = 2 * N;
    localparam int BEATS = N / 2;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    s_q;
    logic [W-1:0]    c_q;
    logic [KW-1:0]   k_q;
    logic [W-1:0]    prod_q;
    logic            prod_valid_q;
    logic            ready_q;

    logic [W-1:0]    x_ext;
    logic [W-1:0]    x_shift;
    logic            beat_fire;

    // Sign-extend the beat and align it to its digit window (2 bits per digit)
    always_comb begin
        x_ext     = W'(signed'(bus.pp_data));
        x_shift   = x_ext << {k_q, 1'b0};
        beat_fire = bus.pp_valid && ready_q;
    end

    // Control FSM with carry-save datapath; ready is registered so it never
    // depends combinationally on the inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ACCUM;
            s_q          <= '0;
            c_q          <= '0;
            k_q          <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (beat_fire) begin
                        s_q <= s_q ^ c_q ^ x_shift;
                        c_q <= ((s_q & c_q) | (s_q & x_shift) | (c_q & x_shift)) << 1;
                        if (k_q == K_LAST) begin
                            k_q     <= '0;
                            state   <= RESOLVE;
                            ready_q <= 1'b0;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                RESOLVE: begin
                    prod_q       <= s_q + c_q;
                    prod_valid_q <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (bus.prod_ready) begin
                        prod_valid_q <= 1'b0;
                        s_q          <= '0;
                        c_q          <= '0;
                        state        <= ACCUM;
                        ready_q      <= 1'b1;
                    end
                end
                default: begin
                    state   <= ACCUM;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pp_ready   = ready_q;
    assign bus.prod_valid = prod_valid_q;
    assign bus.prod       = prod_q;
    assign bus.busy       = (k_q != '0) || (state != ACCUM);
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb/tb_booth_pp_accumulator.sv - self-checking bench for booth_pp_accumulator
module tb_booth_pp_accumulator;
    localparam int N = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    booth_pp_accumulator_if #(.N(N)) dif();

    booth_pp_accumulator #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit track_busy = 1'b0;
    int busy_bad   = 0;

    typedef struct {
        int          md;
        int          mr;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[8];

    always @(negedge clk) begin
        if (track_busy && dif.busy !== 1'b1) busy_bad++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%016h required=0x%016h", name, act, exp);
        end
    endtask

    // Partial product of Booth digit i for multiplier mr, as a 34-bit value
    function automatic logic [33:0] booth_pp(input int md, input int mr, input int i);
        logic [32:0] m;
        int          d;
        longint      p;
        m = {mr, 1'b0};
        d = -2 * int'(m[2*i+2]) + int'(m[2*i+1]) + int'(m[2*i]);
        p = longint'(d) * longint'(md);
        return p[33:0];
    endfunction

    task automatic feed(input int md, input int mr, input int bubble_pct, input int nbeats,
                        output int first_wait);
        int beat = 0;
        int cyc  = 0;
        bit rdy;
        first_wait = 0;
        while (beat < nbeats && cyc < 400) begin
            @(negedge clk);
            dif.pp_valid = ($urandom_range(99) >= bubble_pct);
            dif.pp_data  = dif.pp_valid ? booth_pp(md, mr, beat) : 34'($urandom);
            rdy = dif.pp_ready;
            @(posedge clk);
            if (dif.pp_valid && rdy) begin
                if (beat == 0) track_busy = 1'b1;
                beat++;
            end else if (beat == 0) begin
                first_wait++;
            end
            cyc++;
        end
        if (beat < nbeats) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout beats=%0d required=%0d", beat, nbeats);
        end
    endtask

    task automatic take_result(input logic [63:0] exp, input int stall_pct, input string name);
        int          cyc = 0;
        bit          done = 1'b0;
        bit          have = 1'b0;
        int          unstable = 0;
        logic [63:0] held;
        while (!done && cyc < 400) begin
            @(negedge clk);
            dif.pp_valid   = 1'b0;
            dif.prod_ready = ($urandom_range(99) >= stall_pct);
            if (dif.prod_valid) begin
                if (have && dif.prod !== held) unstable++;
                held = dif.prod;
                have = 1'b1;
                if (dif.prod_ready) begin
                    check(name, dif.prod, exp);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            cyc++;
        end
        track_busy = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout no result transfer", name);
        end
        check({name, "_stable"}, 64'(unstable), 64'd0);
    endtask

    initial begin
        int          fw;
        int          bp_bad;
        int          md;
        int          mr;
        logic [63:0] held;

        tbl[0] = '{3, 5, 64'd15};
        tbl[1] = '{int'(32'h80000000), int'(32'h80000000), 64'h4000_0000_0000_0000};
        tbl[2] = '{int'(32'h7FFFFFFF), int'(32'h80000000), 64'hC000_0000_8000_0000};
        tbl[3] = '{-1, -1, 64'd1};
        tbl[4] = '{0, -12345, 64'd0};
        tbl[5] = '{12345, 6789, 64'd83810205};
        tbl[6] = '{-7, 123, 64'hFFFF_FFFF_FFFF_FCA3};
        tbl[7] = '{int'(32'h7FFFFFFF), int'(32'h7FFFFFFF), 64'h3FFF_FFFF_0000_0001};

        dif.pp_valid   = 1'b0;
        dif.pp_data    = '0;
        dif.prod_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_prod", dif.prod, 64'd0);
        check("reset_flags", {61'd0, dif.prod_valid, dif.pp_ready, dif.busy}, 64'd0);
        repeat (2) @(negedge clk);
        check("reset_ready_held_low", {63'd0, dif.pp_ready}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {63'd0, dif.pp_ready}, 64'd1);
        check("busy_idle", {63'd0, dif.busy}, 64'd0);

        // Small positive case with latency checks
        feed(3, 5, 0, 16, fw);
        @(negedge clk);
        dif.pp_valid = 1'b0;
        check("last_beat_drops_ready", {63'd0, dif.pp_ready}, 64'd0);
        check("resolve_not_valid", {63'd0, dif.prod_valid}, 64'd0);
        check("resolve_busy", {63'd0, dif.busy}, 64'd1);
        @(negedge clk);
        check("latency_valid", {63'd0, dif.prod_valid}, 64'd1);
        check("small_prod_early", dif.prod, 64'd15);
        take_result(64'd15, 0, "small_positive");

        // Table of directed vectors, back-to-back with prod_ready high
        for (int i = 0; i < 8; i++) begin
            feed(tbl[i].md, tbl[i].mr, 0, 16, fw);
            check($sformatf("tbl%0d_first_wait", i), 64'(fw), 64'd0);
            take_result(tbl[i].exp, 0, $sformatf("tbl%0d_prod", i));
        end

        // Backpressure on the extreme-range product, pp_valid held high
        feed(int'(32'h80000000), int'(32'h80000000), 0, 16, fw);
        @(negedge clk);
        dif.prod_ready = 1'b0;
        dif.pp_data    = booth_pp(12345, 6789, 0);
        @(negedge clk);
        check("bp_valid", {63'd0, dif.prod_valid}, 64'd1);
        check("extreme_prod", dif.prod, 64'h4000_0000_0000_0000);
        held   = dif.prod;
        bp_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dif.prod !== held || dif.pp_ready !== 1'b0 || dif.prod_valid !== 1'b1) bp_bad++;
        end
        check("bp_hold", 64'(bp_bad), 64'd0);
        dif.prod_ready = 1'b1;
        @(posedge clk);
        track_busy = 1'b0;
        feed(12345, 6789, 0, 16, fw);
        check("bp_next_first_wait", 64'(fw), 64'd0);
        take_result(64'd83810205, 0, "bp_next_prod");

        // Bubbles with busy tracking
        @(negedge clk);
        check("busy_before_bubbles", {63'd0, dif.busy}, 64'd0);
        busy_bad = 0;
        feed(-7, 123, 50, 16, fw);
        take_result(64'hFFFF_FFFF_FFFF_FCA3, 30, "bubbles_prod");
        check("bubbles_busy", 64'(busy_bad), 64'd0);

        // Reset mid-operation after 7 beats
        feed(555, -777, 0, 7, fw);
        @(negedge clk);
        dif.pp_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_prod", dif.prod, 64'd0);
        check("midreset_flags", {61'd0, dif.prod_valid, dif.pp_ready, dif.busy}, 64'd0);
        track_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_flags_held", {61'd0, dif.prod_valid, dif.pp_ready, dif.busy}, 64'd0);
        reset = 1'b1;
        feed(1000, -1000, 0, 16, fw);
        take_result(64'hFFFF_FFFF_FFF0_BDC0, 0, "after_reset_prod");

        // Randomised regression against the arithmetic product
        for (int t = 0; t < 1000; t++) begin
            md = int'($urandom);
            mr = int'($urandom);
            if (t % 50 == 0) md = int'(32'h80000000);
            if (t % 70 == 0) mr = int'(32'h80000000);
            feed(md, mr, 20, 16, fw);
            take_result(64'(longint'(md) * longint'(mr)), 30, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
